// File: rtl/bean_field_if.sv
// bean_field_if: frame/hit inputs, pixel query and bean status outputs of the bean field
interface bean_field_if;
  logic frame_tick;
  logic check_hit;
  logic [9:0] x;
  logic [9:0] y;
  logic bean;
  logic [11:0] bean_rgb;
  logic [2:0] bean_idx;
  logic stopped;
  logic [7:0] passed;
  modport master (
    output frame_tick, check_hit, x, y,
    input bean, bean_rgb, bean_idx, stopped, passed
  );
  modport slave (
    input frame_tick, check_hit, x, y,
    output bean, bean_rgb, bean_idx, stopped, passed
  );
endinterface

// File: rtl/bean_field.sv
// bean_field: scrolling bean obstacles with hit-stop and 1-clk pixel query; BEAN_RANDOM_GAP_EN adds LFSR respawn jitter
module bean_field #(
  parameter int N_BEANS = 3,
  parameter int BEAN_W = 30,
  parameter int BEAN_H = 40,
  parameter int FLOOR_Y = 400,
  parameter int SPEED = 5,
  parameter int INIT_X0 = 250,
  parameter int INIT_GAP = 200,
  parameter int RESPAWN_X = 700,
  parameter int HOLD_FRAMES = 30,
  parameter logic [11:0] BEAN_RGB = 12'h8A3
) (
  input logic clk,
  input logic reset,
  bean_field_if.slave bus
);
  typedef enum logic {RUN, STOP} state_t;
  state_t state, state_n;
  logic [15:0] hold_cnt, hold_n;
  logic signed [10:0] pos [N_BEANS];
  logic signed [10:0] pos_n [N_BEANS];
  logic [N_BEANS-1:0] wrap, hit;
  logic [3:0] wraps;
  logic [8:0] sum;
  logic [7:0] passed;
  logic scroll;
  logic signed [11:0] px;
  logic [2:0] idx;
`ifdef BEAN_RANDOM_GAP_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    scroll = 1'b0;
    if (bus.check_hit) begin
      state_n = STOP;
      hold_n = 16'(HOLD_FRAMES);
    end else if (state == RUN) begin
      scroll = bus.frame_tick;
    end else if (bus.frame_tick && hold_cnt != 16'd0) begin
      hold_n = hold_cnt - 16'd1;
      state_n = hold_cnt == 16'd1 ? RUN : STOP;
    end
  end
  always_comb begin
    wraps = '0;
    for (int i = 0; i < N_BEANS; i++) begin
      pos_n[i] = pos[i] - 11'(SPEED);
      wrap[i] = pos_n[i] <= 11'sd0;
      wraps = wraps + 4'(wrap[i]);
    end
    for (int i = 0; i < N_BEANS; i++)
      if (wrap[i])
`ifdef BEAN_RANDOM_GAP_EN
        pos_n[i] = 11'(RESPAWN_X) + 11'(lfsr[6:0]) + (wraps > 4'd1 ? 11'(i * BEAN_W * 2) : 11'd0);
`else
        pos_n[i] = 11'(RESPAWN_X + i * BEAN_W * 2);
`endif
    sum = {1'b0, passed} + 9'(wraps);
  end
  assign px = signed'({2'b00, bus.x});
  always_comb begin
    hit = '0;
    idx = '0;
    for (int i = 0; i < N_BEANS; i++)
      hit[i] = px >= 12'(pos[i]) && px < 12'(pos[i]) + 12'(BEAN_W) &&
               bus.y >= 10'(FLOOR_Y - BEAN_H) && bus.y < 10'(FLOOR_Y);
    // descending scan so the lowest hitting index is the one left in idx
    for (int i = N_BEANS - 1; i >= 0; i--)
      if (hit[i]) idx = 3'(i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      hold_cnt <= '0;
      passed <= '0;
      for (int i = 0; i < N_BEANS; i++) pos[i] <= 11'(INIT_X0 + i * INIT_GAP);
      bus.bean <= 1'b0;
      bus.bean_rgb <= '0;
      bus.bean_idx <= '0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      if (scroll) begin
        for (int i = 0; i < N_BEANS; i++) pos[i] <= pos_n[i];
        passed <= sum[8] ? 8'hFF : sum[7:0];
      end
      bus.bean <= |hit;
      bus.bean_rgb <= |hit ? BEAN_RGB : '0;
      bus.bean_idx <= idx;
    end
  end
  assign bus.stopped = state == STOP;
  assign bus.passed = passed;
endmodule

// File: tb/tb_bean_field.sv
// tb_bean_field: two bean fields (hold-stop 3 frames and frozen-until-reset) against a frame-level model
module tb_bean_field;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic check_hit = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  int checks = 0;
  int errors = 0;
  bit live = 1'b0;
  int mpos [2][N];
  int mst [2];
  int mhold [2];
  int mpassed [2];
  int mbean [2];
  int midx [2];
  logic [15:0] mlf;
  always #5 clk = ~clk;
  bean_field_if if0 ();
  bean_field_if if1 ();
  assign if0.frame_tick = frame_tick;
  assign if0.check_hit = check_hit;
  assign if0.x = x;
  assign if0.y = y;
  assign if1.frame_tick = frame_tick;
  assign if1.check_hit = check_hit;
  assign if1.x = x;
  assign if1.y = y;
  bean_field #(.HOLD_FRAMES(3)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  bean_field #(.HOLD_FRAMES(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  function automatic int hold_of(input int k);
    return k == 0 ? 3 : 0;
  endfunction
  function automatic int respawn(input int i, input int w);
`ifdef BEAN_RANDOM_GAP_EN
    return 700 + int'(mlf[6:0]) + (w > 1 ? i * 60 : 0);
`else
    return 700 + i * 60 + 0 * w;
`endif
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // frame-level model: pixel result uses positions before this edge's scroll
  initial forever begin
    int w, np;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < N; i++) mpos[k][i] = 250 + 200 * i;
        mst[k] = 0; mhold[k] = 0; mpassed[k] = 0; mbean[k] = 0; midx[k] = 0;
      end else begin
        mbean[k] = 0;
        midx[k] = 0;
        for (int i = N - 1; i >= 0; i--)
          if (int'(x) >= mpos[k][i] && int'(x) < mpos[k][i] + 30 && int'(y) >= 360 && int'(y) < 400) begin
            mbean[k] = 1;
            midx[k] = i;
          end
        if (check_hit) begin
          mst[k] = 1;
          mhold[k] = hold_of(k);
        end else if (mst[k] != 0) begin
          if (frame_tick && mhold[k] > 0) begin
            mhold[k]--;
            if (mhold[k] == 0) mst[k] = 0;
          end
        end else if (frame_tick) begin
          w = 0;
          for (int i = 0; i < N; i++) if (mpos[k][i] - 5 <= 0) w++;
          for (int i = 0; i < N; i++) begin
            np = mpos[k][i] - 5;
            if (np <= 0) np = respawn(i, w);
            mpos[k][i] = np;
          end
          mpassed[k] = mpassed[k] + w > 255 ? 255 : mpassed[k] + w;
        end
      end
    end
    mlf = reset ? 16'hACE1 : {mlf[14:0], mlf[15] ^ mlf[13] ^ mlf[12] ^ mlf[10]};
  end
  always @(negedge clk) if (live) begin
    chk("bean0", int'(if0.bean), mbean[0]);
    chk("idx0", int'(if0.bean_idx), midx[0]);
    chk("rgb0", int'(if0.bean_rgb), mbean[0] != 0 ? 'h8A3 : 0);
    chk("stop0", int'(if0.stopped), mst[0]);
    chk("passed0", int'(if0.passed), mpassed[0]);
    chk("bean1", int'(if1.bean), mbean[1]);
    chk("idx1", int'(if1.bean_idx), midx[1]);
    chk("rgb1", int'(if1.bean_rgb), mbean[1] != 0 ? 'h8A3 : 0);
    chk("stop1", int'(if1.stopped), mst[1]);
    chk("passed1", int'(if1.passed), mpassed[1]);
  end
  task automatic cyc(input logic ft, input logic ch);
    frame_tick = ft;
    check_hit = ch;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    check_hit = 1'b0;
  endtask
  task automatic query(input int qx, input int qy);
    x = 10'(qx);
    y = 10'(qy);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    live = 1'b1;
    reset = 1'b0;
    chk("rst_stopped", int'(if0.stopped), 0);
    chk("rst_passed", int'(if0.passed), 0);
    chk("rst_bean", int'(if0.bean), 0);
    chk("rst_idx", int'(if0.bean_idx), 0);
    query(250, 360);
    chk("q_in_bean", int'(if0.bean), 1);
    chk("q_in_idx", int'(if0.bean_idx), 0);
    chk("q_in_rgb", int'(if0.bean_rgb), 'h8A3);
    query(280, 360);
    chk("q_xedge", int'(if0.bean), 0);
    query(250, 400);
    chk("q_yedge", int'(if0.bean), 0);
    query(279, 399);
    chk("q_corner", int'(if0.bean), 1);
    query(249, 360);
    chk("q_left", int'(if0.bean), 0);
    query(450, 360);
    chk("q_idx1", int'(if0.bean_idx), 1);
    cyc(1, 0);
    chk("m_pos0_t1", mpos[0][0], 245);
    chk("m_pos1_t1", mpos[0][1], 445);
    chk("m_pos2_t1", mpos[0][2], 645);
    query(245, 360);
    chk("q_t1_in", int'(if0.bean), 1);
    query(244, 360);
    chk("q_t1_out", int'(if0.bean), 0);
    repeat (49) cyc(1, 0);
    chk("wrap_passed", int'(if0.passed), 1);
    chk("m_wrap_pos0", mpos[0][0], 700);
    query(700, 360);
    chk("q_wrap_bean", int'(if0.bean), 1);
    chk("q_wrap_idx", int'(if0.bean_idx), 0);
    cyc(0, 1);
    chk("hit_stop0", int'(if0.stopped), 1);
    chk("hit_stop1", int'(if1.stopped), 1);
    cyc(1, 0);
    cyc(1, 0);
    chk("hold_t2", int'(if0.stopped), 1);
    cyc(1, 0);
    chk("hold_expire", int'(if0.stopped), 0);
    chk("hold_frozen", int'(if1.stopped), 1);
    chk("m_hold_pos1", mpos[0][1], 200);
    cyc(1, 0);
    chk("m_resume_pos1", mpos[0][1], 195);
    chk("m_frozen_pos1", mpos[1][1], 200);
    do_reset;
    cyc(0, 1);
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 1);
    chk("expire_hit", int'(if0.stopped), 1);
    cyc(1, 0);
    cyc(1, 0);
    chk("reload_t2", int'(if0.stopped), 1);
    cyc(1, 0);
    chk("reload_expire", int'(if0.stopped), 0);
    chk("m_reload_pos0", mpos[0][0], 250);
    do_reset;
    cyc(1, 1);
    chk("sim_stop0", int'(if0.stopped), 1);
    chk("sim_stop1", int'(if1.stopped), 1);
    chk("m_sim_pos0", mpos[0][0], 250);
    repeat (100) cyc(1, 0);
    chk("frozen_100", int'(if1.stopped), 1);
    chk("m_frozen_pos", mpos[1][0], 250);
    query(250, 360);
    chk("frozen_bean", int'(if1.bean), 1);
    do_reset;
    chk("rst_stop_run", int'(if1.stopped), 0);
    chk("m_rst_pos", mpos[1][0], 250);
    query(250, 360);
    chk("rst_q0", int'(if0.bean), 1);
    chk("rst_q1", int'(if1.bean), 1);
    do_reset;
    for (int c = 0; c < 16000; c++) begin
      frame_tick = 1'b1;
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(340, 420));
      @(posedge clk);
      #1;
    end
    frame_tick = 1'b0;
    chk("sat_passed0", int'(if0.passed), 255);
    chk("sat_passed1", int'(if1.passed), 255);
    chk("m_sat_passed", mpassed[0], 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
